mem_stage_lsu: RTL and testbench

Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register. It takes the registered ALU address, store data, funct3 and MemRead/MemWrite, and performs one access per instruction on a valid/ready data bus. It handles byte-lane alignment, store strobes and load sign/zero extension, and stalls the pipeline while the bus is busy. The extended load result feeds MEM/WB.

---
 rtl/mem_stage_lsu.sv | 188 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// +----------------------------------------------------------------------------+
// | mem_stage_lsu : memory-stage load/store unit on a valid/ready data bus     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             load_q, load_d;
  logic [31:0]      load_data_q, load_data_d;

  logic        op;
  logic        illegal;
  logic        misaligned;
  logic        fault_comb;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rd_shifted;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // Request decode: a store wins when both MemRead and MemWrite are set.
  always_comb begin
    op         = MemRead_in | MemWrite_in;
    illegal    = (funct3_in == 3'b011) | (funct3_in == 3'b110) | (funct3_in == 3'b111)
               | (MemWrite_in & funct3_in[2]);
    misaligned = ((funct3_in[1:0] == 2'b01) & addr_in[0])
               | ((funct3_in == 3'b010) & (addr_in[1:0] != 2'b00));
    fault_comb = op & (illegal | misaligned);
  end

  always_comb begin
    lane_wdata = store_data_in;
    lane_wstrb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        lane_wdata = {4{store_data_in[7:0]}};
        lane_wstrb = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data_in[15:0]}};
        lane_wstrb = 4'b0011 << addr_in[1:0];
      end
      default: begin
        lane_wdata = store_data_in;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Extraction relies on the offset latched at issue, not the live address.
  always_comb begin
    rd_shifted = bus_rdata >> {off_q, 3'b000};
    rd_half    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b100:  load_ext = {24'd0, rd_shifted[7:0]};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_d      = load_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (op & !fault_comb) begin
          state_d     = BUSY;
          cnt_d       = '0;
          timeout_d   = 1'b0;
          bus_we_d    = MemWrite_in;
          bus_addr_d  = {addr_in[31:2], 2'b00};
          bus_wdata_d = lane_wdata;
          bus_wstrb_d = MemWrite_in ? lane_wstrb : 4'b0000;
          f3_d        = funct3_in;
          off_d       = addr_in[1:0];
          load_d      = MemRead_in & !MemWrite_in;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ready) begin
          state_d     = DONE;
          timeout_d   = 1'b0;
          load_data_d = load_q ? load_ext : load_data_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          load_data_d = '0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_q      <= load_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus_req       = (state_q == BUSY);
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign load_data_out = load_data_q;
  assign load_valid    = (state_q == DONE) & load_q & !timeout_q;
  assign fault         = fault_comb | ((state_q == DONE) & timeout_q);
  assign stall_out     = op & !fault_comb & (state_q != DONE);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// +----------------------------------------------------------------------------+
// | tb_mem_stage_lsu : directed self-checking bench for mem_stage_lsu          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        MemRead_in = 1'b0;
  logic        MemWrite_in = 1'b0;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .addr_in(addr_in), .store_data_in(store_data_in), .funct3_in(funct3_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .stall_out(stall_out), .load_data_out(load_data_out), .load_valid(load_valid),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] a, input logic [2:0] f3, input logic rd,
                         input logic wr, input logic [31:0] sd);
    addr_in = a; funct3_in = f3; MemRead_in = rd; MemWrite_in = wr; store_data_in = sd;
    #1;
  endtask

  task automatic release_op();
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    #1;
  endtask

  // Presents one access and steps it into DONE, ready after `waits` idle bus cycles.
  task automatic do_access(input logic [31:0] a, input logic [2:0] f3, input logic rd,
                           input logic wr, input logic [31:0] sd, input int waits,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           output int n_stall);
    present(a, f3, rd, wr, sd);
    n_stall = 0;
    chk("present_no_req", {31'd0, bus_req}, 32'd0);
    chk("present_no_fault", {31'd0, fault}, 32'd0);
    if (stall_out) n_stall++;
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk("busy_req", {31'd0, bus_req}, 32'd1);
      chk("busy_addr", bus_addr, exp_addr);
      chk("busy_we", {31'd0, bus_we}, {31'd0, wr});
      chk("busy_wstrb", {28'd0, bus_wstrb}, {28'd0, exp_strb});
      if (wr) chk("busy_wdata", bus_wdata, exp_wdata);
      chk("busy_no_valid", {31'd0, load_valid}, 32'd0);
      if (stall_out) n_stall++;
      if (i == waits) begin
        bus_ready = 1'b1;
        bus_rdata = rdata;
      end
      tick();
      bus_ready = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic check_done(input string tag, input logic exp_valid, input logic [31:0] exp_data);
    chk({tag, "_done_stall"}, {31'd0, stall_out}, 32'd0);
    chk({tag, "_done_valid"}, {31'd0, load_valid}, {31'd0, exp_valid});
    chk({tag, "_done_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
    if (exp_valid) chk({tag, "_done_data"}, load_data_out, exp_data);
    release_op();
    tick();
    chk({tag, "_idle_valid"}, {31'd0, load_valid}, 32'd0);
    if (exp_valid) chk({tag, "_idle_hold"}, load_data_out, exp_data);
  endtask

  initial begin
    #3;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk("rst_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // LB 0x103: byte 3 of 0x80FF_1234 is 0x80, sign-extended
    do_access(32'h103, 3'b000, 1'b1, 1'b0, 32'h0, 0, 32'h80FF_1234,
              32'h100, 4'b0000, 32'h0, stalls);
    chk("lb_stalls", stalls, 32'd2);
    check_done("lb", 1'b1, 32'hFFFF_FF80);

    do_access(32'h202, 3'b101, 1'b1, 1'b0, 32'h0, 0, 32'hABCD_0000,
              32'h200, 4'b0000, 32'h0, stalls);
    check_done("lhu", 1'b1, 32'h0000_ABCD);
    do_access(32'h202, 3'b001, 1'b1, 1'b0, 32'h0, 0, 32'hABCD_0000,
              32'h200, 4'b0000, 32'h0, stalls);
    check_done("lh", 1'b1, 32'hFFFF_ABCD);

    // LBU at offset 1 picks 0x12 from 0x80FF_1234
    do_access(32'h105, 3'b100, 1'b1, 1'b0, 32'h0, 1, 32'h80FF_1234,
              32'h104, 4'b0000, 32'h0, stalls);
    chk("lbu_stalls", stalls, 32'd3);
    check_done("lbu", 1'b1, 32'h0000_0012);

    do_access(32'h306, 3'b001, 1'b0, 1'b1, 32'h1234_BEEF, 0, 32'h0,
              32'h304, 4'b1100, 32'hBEEF_BEEF, stalls);
    check_done("sh", 1'b0, 32'h0);
    do_access(32'h301, 3'b000, 1'b0, 1'b1, 32'h0000_0055, 0, 32'h0,
              32'h300, 4'b0010, 32'h5555_5555, stalls);
    check_done("sb", 1'b0, 32'h0);

    do_access(32'h400, 3'b010, 1'b1, 1'b0, 32'h0, 3, 32'h1357_9BDF,
              32'h400, 4'b0000, 32'h0, stalls);
    chk("lw_stalls", stalls, 32'd5);
    check_done("lw", 1'b1, 32'h1357_9BDF);

    // Both read and write set: behaves as a store, no load result
    do_access(32'h700, 3'b010, 1'b1, 1'b1, 32'hCAFE_F00D, 0, 32'h1111_1111,
              32'h700, 4'b1111, 32'hCAFE_F00D, stalls);
    check_done("both", 1'b0, 32'h0);
    chk("both_hold_prev", load_data_out, 32'h1357_9BDF);

    present(32'h402, 3'b010, 1'b1, 1'b0, 32'h0);
    chk("lw_mis_fault", {31'd0, fault}, 32'd1);
    chk("lw_mis_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("lw_mis_noreq", {31'd0, bus_req}, 32'd0);
    chk("lw_mis_fault2", {31'd0, fault}, 32'd1);
    present(32'h203, 3'b101, 1'b1, 1'b0, 32'h0);
    chk("lhu_mis_fault", {31'd0, fault}, 32'd1);
    present(32'h400, 3'b011, 1'b1, 1'b0, 32'h0);
    chk("f3_011_fault", {31'd0, fault}, 32'd1);
    chk("f3_011_stall", {31'd0, stall_out}, 32'd0);
    present(32'h400, 3'b100, 1'b0, 1'b1, 32'h0);
    chk("sbu_fault", {31'd0, fault}, 32'd1);
    tick();
    chk("sbu_noreq", {31'd0, bus_req}, 32'd0);
    release_op();
    chk("released_fault", {31'd0, fault}, 32'd0);

    // SW with no bus_ready: 16 BUSY cycles, then a DONE carrying the fault
    present(32'h500, 3'b010, 1'b0, 1'b1, 32'hA5A5_A5A5);
    chk("to_present_stall", {31'd0, stall_out}, 32'd1);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_busy_req", {31'd0, bus_req}, 32'd1);
      chk("to_busy_stall", {31'd0, stall_out}, 32'd1);
      tick();
    end
    chk("to_done_req", {31'd0, bus_req}, 32'd0);
    chk("to_done_fault", {31'd0, fault}, 32'd1);
    chk("to_done_stall", {31'd0, stall_out}, 32'd0);
    chk("to_done_valid", {31'd0, load_valid}, 32'd0);
    release_op();
    tick();
    chk("to_idle_fault", {31'd0, fault}, 32'd0);
    chk("to_idle_req", {31'd0, bus_req}, 32'd0);

    // Reset asserted in the second BUSY cycle abandons the access
    present(32'h600, 3'b010, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    chk("rb_busy_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_req_cleared", {31'd0, bus_req}, 32'd0);
    chk("rb_addr_cleared", bus_addr, 32'd0);
    chk("rb_data_cleared", load_data_out, 32'd0);
    release_op();
    bus_ready = 1'b1;
    bus_rdata = 32'h7777_7777;
    tick();
    rst = 1'b1;
    tick();
    chk("rb_late_valid", {31'd0, load_valid}, 32'd0);
    chk("rb_late_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("rb_late_valid2", {31'd0, load_valid}, 32'd0);
    chk("rb_late_data", load_data_out, 32'd0);
    bus_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
